// File: rtl/dht11_reader_pkg.sv
// Shared definitions for the DHT11 single-wire reader: FSM states, frame layout
// and a byte extractor for the 40-bit MSB-first frame.
package dht11_reader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_RELEASE,
        S_RESP_L,
        S_RESP_H,
        S_BIT_L,
        S_BIT_H,
        S_CHECK,
        S_FINISH
    } state_t;

    localparam int FRAME_BITS = 40;

    // Byte 0 is the first byte on the wire and lands in the top of the shift register.
    localparam int BYTE_HUM_INT = 0;
    localparam int BYTE_HUM_DEC = 1;
    localparam int BYTE_TMP_INT = 2;
    localparam int BYTE_TMP_DEC = 3;
    localparam int BYTE_SUM     = 4;

    function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame, input int idx);
        return frame[(FRAME_BITS - 1 - 8 * idx) -: 8];
    endfunction

endpackage

// File: rtl/dht11_reader_tick.sv
// Free-running 1 us tick generator: one-cycle pulse every CLK_HZ/1e6 clocks.
module us_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire master: start pulse, response handshake, 40-bit capture,
// checksum verification and publication of {humidity, temperature}.
module dht11_reader #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int START_LOW_US  = 18000,
    parameter int RELEASE_US    = 30,
    parameter int BIT_THRESH_US = 40,
    parameter int TIMEOUT_US    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    inout  wire         dht_io,
    output logic [15:0] out_data,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        error
);

    import dht11_reader_pkg::*;

    localparam int US_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int US_W   = $clog2(US_MAX + 1);

    state_t                 state;
    state_t                 state_next;
    logic                   tick;
    logic                   sync_1;
    logic                   sync_2;
    logic                   sync_prev;
    logic                   rise;
    logic                   fall;
    logic                   timed_out;
    logic [US_W-1:0]        us_cnt;
    logic [5:0]             bit_cnt;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [9:0]             sum;
    logic                   checksum_ok;
    logic                   frame_ok;

    us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // The host only ever pulls low; a high level comes from the external pull-up.
    assign dht_io = (state == S_START) ? 1'b0 : 1'bz;

    assign rise      = sync_2 & ~sync_prev;
    assign fall      = ~sync_2 & sync_prev;
    assign timed_out = (us_cnt == US_W'(TIMEOUT_US));

    assign sum = {2'b00, frame_byte(shift_reg, BYTE_HUM_INT)}
               + {2'b00, frame_byte(shift_reg, BYTE_HUM_DEC)}
               + {2'b00, frame_byte(shift_reg, BYTE_TMP_INT)}
               + {2'b00, frame_byte(shift_reg, BYTE_TMP_DEC)};
    assign checksum_ok = ((sum & 10'h0FF) == {2'b00, frame_byte(shift_reg, BYTE_SUM)});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE) && (state != S_FINISH);
        done       = (state == S_FINISH);
        valid      = done && frame_ok;
        error      = done && !frame_ok;
        case (state)
            S_IDLE:    if (start) state_next = S_START;
            S_START:   if (tick && us_cnt == US_W'(START_LOW_US - 1)) state_next = S_RELEASE;
            S_RELEASE: if (tick && us_cnt == US_W'(RELEASE_US - 1)) state_next = S_RESP_L;
            S_RESP_L:  if (rise) state_next = S_RESP_H; else if (timed_out) state_next = S_FINISH;
            S_RESP_H:  if (fall) state_next = S_BIT_L;  else if (timed_out) state_next = S_FINISH;
            S_BIT_L:   if (rise) state_next = S_BIT_H;  else if (timed_out) state_next = S_FINISH;
            S_BIT_H: begin
                if (fall) begin
                    state_next = (bit_cnt == 6'(FRAME_BITS - 1)) ? S_CHECK : S_BIT_L;
                end else if (timed_out) begin
                    state_next = S_FINISH;
                end
            end
            S_CHECK:   state_next = S_FINISH;
            S_FINISH:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Synchronizer resets high to match the idle pulled-up line and avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
            us_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            out_data  <= 16'h0000;
            frame_ok  <= 1'b0;
        end else begin
            sync_1    <= dht_io;
            sync_2    <= sync_1;
            sync_prev <= sync_2;

            if (state_next != state) begin
                us_cnt <= '0;
            end else if (tick) begin
                us_cnt <= us_cnt + 1'b1;
            end

            if (state == S_IDLE && start) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (state == S_BIT_H && fall) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], (us_cnt > US_W'(BIT_THRESH_US))};
                bit_cnt   <= bit_cnt + 1'b1;
            end

            // Only integer bytes are published; a failed checksum keeps the last good word.
            if (state == S_CHECK) begin
                frame_ok <= checksum_ok;
                if (checksum_ok) begin
                    out_data <= {frame_byte(shift_reg, BYTE_HUM_INT), frame_byte(shift_reg, BYTE_TMP_INT)};
                end
            end else if (state_next == S_FINISH) begin
                frame_ok <= 1'b0;
            end
        end
    end

endmodule
